// File: rtl/mem_arbiter_if.sv
// ============================================================================
//  Module   : mem_arbiter_if
//  Purpose  : Cache-side and memory-side bus bundle for mem_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_arbiter_if #(
  parameter int LINE_WORDS = 4
) ();
  logic                       i_rd_req;
  logic [31:0]                i_rd_addr;
  logic                       i_rd_rdy;
  logic                       i_ret_valid;
  logic                       i_ret_last;
  logic [31:0]                i_ret_data;

  logic                       d_rd_req;
  logic [31:0]                d_rd_addr;
  logic                       d_rd_rdy;
  logic                       d_ret_valid;
  logic                       d_ret_last;
  logic [31:0]                d_ret_data;

  logic                       d_wr_req;
  logic [31:0]                d_wr_addr;
  logic [32*LINE_WORDS-1:0]   d_wr_data;
  logic                       d_wr_rdy;
  logic                       d_wr_done;

  logic                       m_req;
  logic                       m_we;
  logic [31:0]                m_addr;
  logic                       m_ack;
  logic                       m_wvalid;
  logic [31:0]                m_wdata;
  logic                       m_wlast;
  logic                       m_wready;
  logic                       m_bvalid;
  logic                       m_rvalid;
  logic [31:0]                m_rdata;
  logic                       m_rlast;

  // Arbiter view
  modport slave (
    input  i_rd_req, i_rd_addr, d_rd_req, d_rd_addr,
           d_wr_req, d_wr_addr, d_wr_data,
           m_ack, m_wready, m_bvalid, m_rvalid, m_rdata, m_rlast,
    output i_rd_rdy, i_ret_valid, i_ret_last, i_ret_data,
           d_rd_rdy, d_ret_valid, d_ret_last, d_ret_data,
           d_wr_rdy, d_wr_done,
           m_req, m_we, m_addr, m_wvalid, m_wdata, m_wlast
  );

  // Caches plus memory view
  modport master (
    output i_rd_req, i_rd_addr, d_rd_req, d_rd_addr,
           d_wr_req, d_wr_addr, d_wr_data,
           m_ack, m_wready, m_bvalid, m_rvalid, m_rdata, m_rlast,
    input  i_rd_rdy, i_ret_valid, i_ret_last, i_ret_data,
           d_rd_rdy, d_ret_valid, d_ret_last, d_ret_data,
           d_wr_rdy, d_wr_done,
           m_req, m_we, m_addr, m_wvalid, m_wdata, m_wlast
  );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Single-outstanding arbiter between ICache/DCache line reads,
//             DCache writebacks and one memory port.
//  Options  : MEM_ARB_ROUND_ROBIN_EN - round-robin between D-read and I-read
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int LINE_WORDS = 4
) (
  input  logic            clk,
  input  logic            rst,
  mem_arbiter_if.slave    bus,
  output logic            busy
);

  localparam int              CW         = $clog2(LINE_WORDS);
  localparam int              OFFS       = CW + 2;
  localparam logic [31:0]     ALIGN_MASK = ~((32'd1 << OFFS) - 32'd1);
  localparam logic [CW-1:0]   LAST_BEAT  = CW'(LINE_WORDS - 1);
  localparam logic            OWN_I      = 1'b0;
  localparam logic            OWN_D      = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_ADDR = 3'd3,
    WR_DATA = 3'd4,
    WR_RESP = 3'd5
  } state_e;

  state_e                       state_q, state_d;
  logic [31:0]                  addr_q, addr_d;
  logic                         owner_q, owner_d;
  logic [LINE_WORDS-1:0][31:0]  line_q, line_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic                         grant_d_rd;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // rr_q set means the ICache is favoured on the next tie
  logic rr_q, rr_d;
  assign grant_d_rd = bus.d_rd_req && (!bus.i_rd_req || !rr_q);
`else
  assign grant_d_rd = bus.d_rd_req;
`endif

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      owner_q <= OWN_I;
      line_q  <= '0;
      cnt_q   <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      owner_q <= owner_d;
      line_q  <= line_d;
      cnt_q   <= cnt_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_q    <= rr_d;
`endif
    end
  end

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    owner_d         = owner_q;
    line_d          = line_q;
    cnt_d           = cnt_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    rr_d            = rr_q;
`endif
    bus.i_rd_rdy    = 1'b0;
    bus.d_rd_rdy    = 1'b0;
    bus.d_wr_rdy    = 1'b0;
    bus.i_ret_valid = 1'b0;
    bus.i_ret_last  = 1'b0;
    bus.i_ret_data  = '0;
    bus.d_ret_valid = 1'b0;
    bus.d_ret_last  = 1'b0;
    bus.d_ret_data  = '0;
    bus.d_wr_done   = 1'b0;
    bus.m_req       = 1'b0;
    bus.m_we        = 1'b0;
    bus.m_addr      = '0;
    bus.m_wvalid    = 1'b0;
    bus.m_wdata     = '0;
    bus.m_wlast     = 1'b0;

    case (state_q)
      IDLE: begin
        // Grants are suppressed while reset is held so no rdy leaks out
        if (!rst) begin
          if (bus.d_wr_req) begin
            bus.d_wr_rdy = 1'b1;
            addr_d       = bus.d_wr_addr & ALIGN_MASK;
            owner_d      = OWN_D;
            line_d       = bus.d_wr_data;
            state_d      = WR_ADDR;
          end else if (grant_d_rd) begin
            bus.d_rd_rdy = 1'b1;
            addr_d       = bus.d_rd_addr & ALIGN_MASK;
            owner_d      = OWN_D;
            state_d      = RD_ADDR;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            rr_d         = 1'b1;
`endif
          end else if (bus.i_rd_req) begin
            bus.i_rd_rdy = 1'b1;
            addr_d       = bus.i_rd_addr & ALIGN_MASK;
            owner_d      = OWN_I;
            state_d      = RD_ADDR;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            rr_d         = 1'b0;
`endif
          end
        end
      end

      RD_ADDR: begin
        bus.m_req  = 1'b1;
        bus.m_addr = addr_q;
        if (bus.m_ack) state_d = RD_DATA;
      end

      RD_DATA: begin
        if (owner_q == OWN_D) begin
          bus.d_ret_valid = bus.m_rvalid;
          bus.d_ret_last  = bus.m_rvalid && bus.m_rlast;
          bus.d_ret_data  = bus.m_rdata;
        end else begin
          bus.i_ret_valid = bus.m_rvalid;
          bus.i_ret_last  = bus.m_rvalid && bus.m_rlast;
          bus.i_ret_data  = bus.m_rdata;
        end
        if (bus.m_rvalid && bus.m_rlast) state_d = IDLE;
      end

      WR_ADDR: begin
        bus.m_req  = 1'b1;
        bus.m_we   = 1'b1;
        bus.m_addr = addr_q;
        if (bus.m_ack) begin
          cnt_d   = '0;
          state_d = WR_DATA;
        end
      end

      WR_DATA: begin
        bus.m_wvalid = 1'b1;
        bus.m_wdata  = line_q[cnt_q];
        bus.m_wlast  = (cnt_q == LAST_BEAT);
        if (bus.m_wready) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = WR_RESP;
          end else begin
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end

      WR_RESP: begin
        if (bus.m_bvalid) begin
          bus.d_wr_done = 1'b1;
          state_d       = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 4, meaning 32-bit beats per cache line (power of two, 2..16).
REQ-002 SHALL have port clk, input, 1, system clock.
REQ-003 SHALL have port rst, input, 1, reset; synchronous to clk, active-high.
REQ-004 SHALL have ports i_rd_req in 1 / i_rd_addr in 32 / i_rd_rdy out 1, meaning ICache line-read request, address and accept pulse.
REQ-005 SHALL have ports i_ret_valid out 1 / i_ret_last out 1 / i_ret_data out 32, meaning ICache refill return beats.
REQ-006 SHALL have ports d_rd_req in 1 / d_rd_addr in 32 / d_rd_rdy out 1 / d_ret_valid out 1 / d_ret_last out 1 / d_ret_data out 32, meaning the same for DCache.
REQ-007 SHALL have ports d_wr_req in 1 / d_wr_addr in 32 / d_wr_data in 32*LINE_WORDS / d_wr_rdy out 1 / d_wr_done out 1, meaning DCache dirty-line writeback.
REQ-008 SHALL have ports m_req out 1 / m_we out 1 / m_addr out 32 / m_ack in 1, meaning memory address phase.
REQ-009 SHALL have ports m_wvalid out 1 / m_wdata out 32 / m_wlast out 1 / m_wready in 1 / m_bvalid in 1, meaning memory write-data and write-response phases.
REQ-010 SHALL have ports m_rvalid in 1 / m_rdata in 32 / m_rlast in 1, meaning memory read-data phase.
REQ-011 SHALL have port busy, output, 1, meaning a transaction is in flight (state not IDLE).

Function
REQ-012 SHALL implement FSM states IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, with one transaction outstanding at a time.
REQ-013 In IDLE, with any request high, SHALL select one: d_wr_req first always; between d_rd_req and i_rd_req per REQ-026/027.
REQ-014 On selection SHALL pulse the winner's *_rdy for exactly one cycle and latch address (line-aligned: low log2(LINE_WORDS)+2 bits forced to 0), requester ID and, for writes, the whole d_wr_data line.
REQ-015 The cycle after selection SHALL enter RD_ADDR (reads) or WR_ADDR (writes); m_req=1, m_we=1 only for writes, m_addr=latched address, held stable until m_ack.
REQ-016 RD_ADDR on m_ack SHALL go to RD_DATA; each m_rvalid SHALL be forwarded combinationally to the owner's *_ret_valid/_data/_last; the non-owner's ret_valid SHALL stay 0.
REQ-017 RD_DATA on m_rvalid&&m_rlast SHALL return to IDLE next cycle.
REQ-018 WR_ADDR on m_ack SHALL go to WR_DATA with beat counter=0.
REQ-019 WR_DATA SHALL drive m_wvalid=1, m_wdata=word[counter] (word 0 = bits 31:0), m_wlast=(counter==LINE_WORDS-1); counter increments on m_wvalid&&m_wready; last beat accepted -> WR_RESP.
REQ-020 WR_RESP on m_bvalid SHALL pulse d_wr_done one cycle and return to IDLE.
REQ-021 Requests arriving while busy SHALL be held by requesters and are not acknowledged; requests are level-sensitive, not latched.
REQ-022 Simultaneous m_ack and state entry: m_ack SHALL be sampled only in RD_ADDR/WR_ADDR; m_rvalid outside RD_DATA, m_wready outside WR_DATA and m_bvalid outside WR_RESP SHALL be ignored.
REQ-023 Minimum latency from request in IDLE to m_req SHALL be 1 cycle; back-to-back transactions SHALL have one IDLE cycle between them.

Reset
REQ-024 With rst=1 at a clk edge SHALL enter IDLE, clear counter, owner and RR pointer; all outputs 0 next cycle, including mid-transaction (in-flight beats dropped, no ret_valid/done emitted).
REQ-025 All outputs SHALL be 0 in IDLE except *_rdy pulses.

Configuration
REQ-026 With macro MEM_ARB_ROUND_ROBIN_EN defined: D-read vs I-read tie SHALL go to the requester not granted most recently (pointer initialised to favour DCache after reset, updated on each read grant).
REQ-027 Without it: fixed priority, d_rd_req SHALL always beat i_rd_req.

Verification
REQ-028 Single I-read 0x1C00_0014, LINE_WORDS=4 -> m_addr=0x1C00_0010, i_rdy pulse 1 cycle, 4 i_ret_valid beats, i_ret_last on beat 4, busy falls next cycle.
REQ-029 d_wr_req and d_rd_req and i_rd_req same cycle -> write granted first, then D-read; with RR_EN next tie after that gives I-read.
REQ-030 Writeback line 0x4433_2211..0xDDCC_BBAA, m_wready toggling 1/0 -> m_wdata order 0x4433_2211 first, m_wlast only beat 4, d_wr_done one pulse after m_bvalid.
REQ-031 Without RR_EN, d_rd_req and i_rd_req held high together for 3 transactions -> all 3 go to DCache; with RR_EN -> D, I, D.
REQ-032 rst asserted during RD_DATA beat 2 -> next cycle IDLE, busy=0, later m_rvalid produce no ret_valid; a fresh request is served normally.
